// File: rtl/wb_serial_adder_slave_pkg.sv
// Shared definitions for the Wishbone serial-adder slave: register map,
// control/status bit positions, engine state type and a byte-lane helper.
package wb_serial_adder_slave_pkg;

    localparam logic [7:0] OFS_OPA    = 8'h00;
    localparam logic [7:0] OFS_OPB    = 8'h04;
    localparam logic [7:0] OFS_CTRL   = 8'h08;
    localparam logic [7:0] OFS_STATUS = 8'h0C;
    localparam logic [7:0] OFS_RESULT = 8'h10;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_DONE   = 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_serial_adder_slave_engine.sv
// Bit-serial ripple adder: latches shadow operands on start, adds one bit
// per clock LSB first, and publishes {cout,sum} only when all bits are done.
module serial_add_engine
    import wb_serial_adder_slave_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_pulse_o,
    output logic [WIDTH:0]   result_o
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH:0]   result_q;
    logic             busy_q;

    logic             s_d, c_d;
    logic [WIDTH-1:0] sum_d;

    // Shadows shift right each cycle, so the active bit is always bit 0.
    always_comb begin
        s_d = a_q[0] ^ b_q[0] ^ carry_q;
        c_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        sum_d = sum_q >> 1;
        sum_d[WIDTH-1] = s_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        sum_q   <= '0;
                        carry_q <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= c_d;
                    sum_q   <= sum_d;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        result_q <= {c_d, sum_d};
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Decoded from registers so the top can set DONE on the final edge itself.
    assign done_pulse_o = (state_q == RUN) && (idx_q == LAST_IDX);
    assign busy_o       = busy_q;
    assign result_o     = result_q;

endmodule

// File: rtl/wb_serial_adder_slave.sv
// Wishbone slave wrapping the serial add engine: address decode, one-wait-state
// ack, operand/control/status registers and the level completion interrupt.
module wb_serial_adder_slave
    import wb_serial_adder_slave_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  irq
);

    logic             ack_q;
    logic [31:0]      dat_q;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic             irq_en_q, irq_en_d;
    logic             done_q, done_d;
    logic             irq_q;

    logic             hit, access, wr, rd, start;
    logic [7:0]       ofs;
    logic [31:0]      opa_m, opb_m, rdata;
    logic             unused_bits;

    logic             eng_busy, eng_done;
    logic [WIDTH:0]   eng_result;

    serial_add_engine #(.WIDTH(WIDTH)) u_engine (
        .clk_i        (wb_clk_i),
        .rst_i        (wb_rst_i),
        .start_i      (start),
        .a_i          (opa_q),
        .b_i          (opb_q),
        .busy_o       (eng_busy),
        .done_pulse_o (eng_done),
        .result_o     (eng_result)
    );

    always_comb begin
        hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        ofs    = wbs_adr_i[7:0];
        access = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
        wr     = access & wbs_we_i;
        rd     = access & ~wbs_we_i;

        opa_m = merge_bytes(32'(opa_q), wbs_dat_i, wbs_sel_i);
        opb_m = merge_bytes(32'(opb_q), wbs_dat_i, wbs_sel_i);
        unused_bits = ^{opa_m[31:WIDTH], opb_m[31:WIDTH]};

        opa_d = opa_q;
        opb_d = opb_q;
        if (wr && ofs == OFS_OPA) opa_d = opa_m[WIDTH-1:0];
        if (wr && ofs == OFS_OPB) opb_d = opb_m[WIDTH-1:0];

        start    = wr && (ofs == OFS_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_START];
        irq_en_d = irq_en_q;
        if (wr && ofs == OFS_CTRL && wbs_sel_i[0]) irq_en_d = wbs_dat_i[CTRL_IRQ_EN];

        // Completion is applied last so it beats a same-edge W1C.
        done_d = done_q;
        if (wr && ofs == OFS_STATUS && wbs_sel_i[0] && wbs_dat_i[STAT_DONE]) done_d = 1'b0;
        if (start && !eng_busy) done_d = 1'b0;
        if (eng_done) done_d = 1'b1;

        rdata = '0;
        case (ofs)
            OFS_OPA:    rdata = 32'(opa_q);
            OFS_OPB:    rdata = 32'(opb_q);
            OFS_CTRL:   rdata[CTRL_IRQ_EN] = irq_en_q;
            OFS_STATUS: begin
                rdata[STAT_BUSY] = eng_busy;
                rdata[STAT_DONE] = done_q;
            end
            OFS_RESULT: rdata = 32'(eng_result);
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= access;
            dat_q    <= rd ? rdata : '0;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            irq_q    <= done_d & irq_en_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = {2'b00, irq_q};

endmodule

// File: tb/tb_wb_serial_adder_slave.sv
// Self-checking bench for wb_serial_adder_slave: table-driven add vectors,
// cycle-accurate status/irq model and hand-written corner-case sequences.
module tb_wb_serial_adder_slave;
    import wb_serial_adder_slave_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] wdat, adr;
    logic        ack;
    logic [31:0] rdat_o;
    logic [2:0]  irq;

    wb_serial_adder_slave #(.WIDTH(WIDTH), .BASE_ADDR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (wdat),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat_o),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] r;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // One bus access; returns ack flag, read data, access edge index and latency.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic acked, output logic [31:0] rd,
                           output int unsigned edge_n, output int unsigned lat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0; rd = '0; edge_n = 0; lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1; rd = rdat_o; edge_n = cyc_cnt; lat = i;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int unsigned edge_n);
        logic acked; logic [31:0] rd; int unsigned lat;
        wb_xfer(1'b1, a, d, s, acked, rd, edge_n, lat);
        check("write ack latency", lat, 1);
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d);
        int unsigned e;
        wb_write(BASE + 32'(o), d, 4'hF, e);
    endtask

    task automatic wb_read_chk(input string name, input logic [7:0] o, input logic [31:0] exp);
        logic acked; logic [31:0] rd; int unsigned e, lat; logic [31:0] x;
        exp_q.push_back(exp);
        wb_xfer(1'b0, BASE + 32'(o), '0, 4'hF, acked, rd, e, lat);
        check({name, " ack latency"}, lat, 1);
        x = exp_q.pop_front();
        check(name, rd, x);
    endtask

    // Polls STATUS; expected {DONE,BUSY} derived from the START edge t0.
    task automatic poll_done(input int unsigned t0, input string name);
        logic acked; logic [31:0] rd; int unsigned e, lat, p;
        logic eb, ed;
        for (int k = 0; k < 40; k++) begin
            wb_xfer(1'b0, BASE + 32'(OFS_STATUS), '0, 4'hF, acked, rd, e, lat);
            p  = e - 1;
            eb = (p >= t0) && (p < t0 + WIDTH);
            ed = (p >= t0 + WIDTH);
            check(name, rd, {30'b0, ed, eb});
            if (!acked || rd[1]) return;
        end
        check({name, " done timeout"}, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned t, e;
        logic [31:0] prev;
        logic acked; logic [31:0] rd; int unsigned lat;

        vecs[0] = '{16'h1234, 16'h4321, 17'h05555};
        vecs[1] = '{16'hFFFF, 16'h0001, 17'h10000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
        vecs[3] = '{16'h0000, 16'h0000, 17'h00000};
        vecs[4] = '{16'h8000, 16'h8000, 17'h10000};
        vecs[5] = '{16'hAAAA, 16'h5555, 17'h0FFFF};
        vecs[6] = '{16'h0F0F, 16'hF0F1, 17'h10000};
        vecs[7] = '{16'hABCD, 16'h1234, 17'h0BE01};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; wdat = '0; adr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("reset ack", 32'(ack), 0);
        check("reset dat", rdat_o, 0);
        check("reset irq", 32'(irq), 0);
        wb_read_chk("reset OPA", OFS_OPA, 0);
        wb_read_chk("reset OPB", OFS_OPB, 0);
        wb_read_chk("reset CTRL", OFS_CTRL, 0);
        wb_read_chk("reset STATUS", OFS_STATUS, 0);
        wb_read_chk("reset RESULT", OFS_RESULT, 0);

        prev = 0;
        for (int i = 0; i < 8; i++) begin
            wr(OFS_OPA, 32'(vecs[i].a));
            wr(OFS_OPB, 32'(vecs[i].b));
            wb_write(BASE + 32'(OFS_CTRL), 32'h1, 4'hF, t);
            wb_read_chk("RESULT held mid-run", OFS_RESULT, prev);
            poll_done(t, "vec STATUS");
            wb_read_chk("vec RESULT", OFS_RESULT, 32'(vecs[i].r));
            prev = 32'(vecs[i].r);
        end

        // IRQ timing and W1C.
        wr(OFS_CTRL, 32'h2);
        wr(OFS_OPA, 32'hFFFF);
        wr(OFS_OPB, 32'h0001);
        wb_write(BASE + 32'(OFS_CTRL), 32'h3, 4'hF, t);
        check("irq after START", 32'(irq), 0);
        for (int k = 0; k < WIDTH + 2; k++) begin
            @(posedge clk); #1;
            check("irq timing", 32'(irq), (cyc_cnt >= t + WIDTH) ? 1 : 0);
        end
        wb_read_chk("irq RESULT", OFS_RESULT, 32'h10000);
        wb_read_chk("CTRL readback", OFS_CTRL, 32'h2);
        check("irq held", 32'(irq), 1);
        wr(OFS_STATUS, 32'h2);
        check("irq after W1C", 32'(irq), 0);
        wb_read_chk("STATUS after W1C", OFS_STATUS, 0);

        // W1C on the same edge DONE is set: set wins.
        wb_write(BASE + 32'(OFS_CTRL), 32'h3, 4'hF, t);
        while (cyc_cnt < t + WIDTH - 1) begin
            @(posedge clk); #1;
        end
        wb_write(BASE + 32'(OFS_STATUS), 32'h2, 4'hF, e);
        check("W1C edge alignment", e, t + WIDTH);
        wb_read_chk("set wins STATUS", OFS_STATUS, 32'h2);
        check("set wins irq", 32'(irq), 1);
        wr(OFS_STATUS, 32'h2);
        wb_read_chk("STATUS cleared", OFS_STATUS, 0);

        // Operand write and second START while busy use the shadow copy.
        wr(OFS_OPA, 32'h1234);
        wr(OFS_OPB, 32'h4321);
        wb_write(BASE + 32'(OFS_CTRL), 32'h3, 4'hF, t);
        wr(OFS_OPA, 32'h0000);
        wr(OFS_CTRL, 32'h3);
        poll_done(t, "shadow STATUS");
        wb_read_chk("shadow RESULT", OFS_RESULT, 32'h05555);
        wb_read_chk("OPA updated", OFS_OPA, 0);
        repeat (20) @(posedge clk);
        #1;
        wb_read_chk("no second run STATUS", OFS_STATUS, 32'h2);
        wb_read_chk("no second run RESULT", OFS_RESULT, 32'h05555);

        // Reset mid-operation.
        wr(OFS_OPA, 32'h00FF);
        wb_write(BASE + 32'(OFS_CTRL), 32'h3, 4'hF, t);
        while (cyc_cnt < t + 5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("irq after reset", 32'(irq), 0);
        wb_read_chk("STATUS after reset", OFS_STATUS, 0);
        wb_read_chk("RESULT after reset", OFS_RESULT, 0);
        wb_read_chk("OPA after reset", OFS_OPA, 0);
        wb_read_chk("CTRL after reset", OFS_CTRL, 0);

        // Byte lanes, unmapped offsets and out-of-window access.
        wr(OFS_OPA, 32'h1234);
        wb_write(BASE + 32'(OFS_OPA), 32'h0000_00FF, 4'b0001, e);
        wb_write(BASE + 32'(OFS_OPA), 32'hFFFF_AB00, 4'b0010, e);
        wb_read_chk("OPA byte lanes", OFS_OPA, 32'hABFF);
        wb_read_chk("unmapped read", 8'h20, 0);
        wr(8'h24, 32'hFFFF_FFFF);
        wb_read_chk("OPA after unmapped write", OFS_OPA, 32'hABFF);
        wb_read_chk("OPB after unmapped write", OFS_OPB, 0);
        wb_read_chk("CTRL after unmapped write", OFS_CTRL, 0);
        wb_read_chk("STATUS after unmapped write", OFS_STATUS, 0);
        wb_xfer(1'b0, BASE + 32'h100, '0, 4'hF, acked, rd, e, lat);
        check("out of window no ack", 32'(acked), 0);
        check("out of window dat", rdat_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
